ias_datapath_mc: RTL

//  Multi-channel successor to the single-register IAS datapath: C independent W-bit

---
 rtl/ias_pkg.sv | 16 +
 rtl/ias_chan.sv | 78 +++++++
 rtl/ias_datapath_mc.sv | 110 +++++++++++
 3 files changed

// File: rtl/ias_pkg.sv
// Shared definitions for the multi-channel IAS datapath.
//   - OP_* : per-channel operation encoding driven by the IAS controller
//   - frame_state_t : scan frame tracker states
package ias_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  typedef enum logic {
    FR_IDLE  = 1'b0,
    FR_SHIFT = 1'b1
  } frame_state_t;

endpackage

// File: rtl/ias_chan.sv
// One W-bit IAS channel register.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load_val    : value taken on OP_LOAD
//   op          : channel operation (ias_pkg OP_*)
//   en          : functional update enable
//   scan_mode   : 1 = scan mode, functional path ignored
//   scan_shift  : shift one bit this edge (only used in scan mode)
//   scan_in     : bit entering at the MSB on a shift
//   q           : channel register
//   ovf         : registered pulse, previous INC/DEC left the W-bit range
//   scan_out    : bit leaving at the LSB (q[0])
module ias_chan
  import ias_pkg::*;
#(
  parameter int W    = 32,
  parameter int STEP = 1,
  parameter int SAT  = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] load_val,
  input  logic [1:0]   op,
  input  logic         en,
  input  logic         scan_mode,
  input  logic         scan_shift,
  input  logic         scan_in,
  output logic [W-1:0] q,
  output logic         ovf,
  output logic         scan_out
);

  localparam logic [W:0] STEP_X = (W+1)'(STEP);

  // One extra bit catches the carry out of INC and the borrow out of DEC.
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] q_next;
  logic         ovf_next;

  assign sum      = {1'b0, q} + STEP_X;
  assign diff     = {1'b0, q} - STEP_X;
  assign scan_out = q[0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    q_next   = q;
    ovf_next = 1'b0;
    if (scan_mode) begin
      if (scan_shift) q_next = {scan_in, q[W-1:1]};
    end else if (en) begin
      case (op)
        OP_LOAD: q_next = load_val;
        OP_INC: begin
          ovf_next = sum[W];
          q_next   = (sum[W] && SAT != 0) ? '1 : sum[W-1:0];
        end
        OP_DEC: begin
          ovf_next = diff[W];
          q_next   = (diff[W] && SAT != 0) ? '0 : diff[W-1:0];
        end
        default: q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all flops sample pre-edge values.
    if (reset) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: rtl/ias_datapath_mc.sv
// Multi-channel IAS datapath: C independent W-bit channels sharing one scan
// chain, plus a frame counter that pulses scan_done after C*W shifts.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   data_in    : load values, channel c = data_in[c*W +: W]
//   op         : per-channel op, channel c = op[2c +: 2]
//   reg_en     : per-channel functional update enable
//   data_out   : channel registers, channel c = data_out[c*W +: W]
//   ovf        : per-channel overflow pulse
//   sin, sout  : scan serial in / out (sout = data_out[0])
//   sen        : scan enable (blocks functional updates)
//   scan_ce    : shift strobe in scan mode
//   scan_done  : one-cycle pulse after a complete C*W-shift frame
module ias_datapath_mc
  import ias_pkg::*;
#(
  parameter int W    = 32,
  parameter int C    = 4,
  parameter int STEP = 1,
  parameter int SAT  = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [C*W-1:0] data_in,
  input  logic [2*C-1:0] op,
  input  logic [C-1:0]   reg_en,
  output logic [C*W-1:0] data_out,
  output logic [C-1:0]   ovf,
  input  logic           sin,
  output logic           sout,
  input  logic           sen,
  input  logic           scan_ce,
  output logic           scan_done
);

  localparam int FRAME_LEN = C * W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  logic [C-1:0] chain_bit;
  logic         shift;

  assign shift = sen & scan_ce;
  assign sout  = chain_bit[0];

  // Channel c takes its scan input from channel c+1's LSB; the top channel from sin.
  for (genvar c = 0; c < C; c++) begin : g_chan
    logic link_in;
    if (c == C - 1) begin : g_head
      assign link_in = sin;
    end else begin : g_link
      assign link_in = chain_bit[c+1];
    end

    ias_chan #(
      .W    (W),
      .STEP (STEP),
      .SAT  (SAT)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .load_val   (data_in[c*W +: W]),
      .op         (op[2*c +: 2]),
      .en         (reg_en[c]),
      .scan_mode  (sen),
      .scan_shift (shift),
      .scan_in    (link_in),
      .q          (data_out[c*W +: W]),
      .ovf        (ovf[c]),
      .scan_out   (chain_bit[c])
    );
  end

  frame_state_t     state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FR_IDLE;
      count     <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      scan_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = 1'b0;
    if (!sen) begin
      // Leaving scan mode abandons any partial frame.
      state_next = FR_IDLE;
      count_next = '0;
    end else if (scan_ce) begin
      if (count == LAST) begin
        state_next = FR_IDLE;
        count_next = '0;
        done_next  = 1'b1;
      end else begin
        state_next = FR_SHIFT;
        count_next = count + 1'b1;
      end
    end
  end

endmodule
